// File: rtl/r_alu_arbiter.sv
// Round-robin arbiter and sequencer that shares one combinational R-type ALU among NREQ requesters.
// Each operation is accepted in IDLE, evaluated in EXEC and returned over a valid/ready handshake in RESP.
module r_alu_arbiter #(
    parameter int NREQ = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_instr,
    input  logic [32*NREQ-1:0]   req_rv1,
    input  logic [32*NREQ-1:0]   req_rv2,
    output logic [NREQ-1:0]      resp_valid,
    input  logic [NREQ-1:0]      resp_ready,
    output logic [31:0]          resp_data,
    output logic                 resp_err,
    output logic [31:0]          alu_idata,
    output logic [31:0]          alu_rv1,
    output logic [31:0]          alu_rv2,
    input  logic [31:0]          alu_result,
    output logic                 busy,
    output logic [15:0]          op_count
);

    localparam int IW = (NREQ > 2) ? 2 : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);
    localparam logic [6:0] OPC_OP = 7'b0110011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   last_grant;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   winner;
    logic [IW-1:0]   cand;
    logic            win_found;
    logic            accept;
    logic            resp_done;
    logic            legal;
    logic [31:0]     instr_q;
    logic [31:0]     rv1_q;
    logic [31:0]     rv2_q;
    logic [31:0]     res_q;
    logic            err_q;

    logic [31:0]     instr_in [NREQ];
    logic [31:0]     rv1_in   [NREQ];
    logic [31:0]     rv2_in   [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign instr_in[g] = req_instr[32*g +: 32];
        assign rv1_in[g]   = req_rv1[32*g +: 32];
        assign rv2_in[g]   = req_rv2[32*g +: 32];
    end

    // Search starts one past the previous winner, so every holder of req_valid is reached within NREQ grants.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path can infer a latch.
        win_found = 1'b0;
        winner    = '0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(last_grant) + k) % NREQ);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                winner    = cand;
            end
        end
    end

    always_comb begin
        legal = 1'b0;
        if (instr_q[6:0] == OPC_OP && !instr_q[31] && instr_q[29:25] == 5'd0) begin
            case ({instr_q[30], instr_q[14:12]})
                4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011,
                4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111: legal = 1'b1;
                default:                                     legal = 1'b0;
            endcase
        end
    end

    assign accept    = (state == IDLE) && win_found;
    assign resp_done = (state == RESP) && resp_ready[owner];

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (win_found) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (resp_ready[owner]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: the operand latches are reset too, because the ALU ports must read zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= LAST_IDX;
            owner      <= '0;
            instr_q    <= '0;
            rv1_q      <= '0;
            rv2_q      <= '0;
        end else if (accept) begin
            last_grant <= winner;
            owner      <= winner;
            instr_q    <= instr_in[winner];
            rv1_q      <= rv1_in[winner];
            rv2_q      <= rv2_in[winner];
        end
    end

    // An illegal word still produces a response, but the ALU output is replaced by zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
            err_q <= 1'b0;
        end else if (state == EXEC) begin
            res_q <= legal ? alu_result : 32'd0;
            err_q <= !legal;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (resp_done && !err_q) begin
            op_count <= op_count + 16'd1;
        end
    end

    assign req_ready  = accept ? (NREQ'(1) << winner) : '0;
    assign resp_valid = (state == RESP) ? (NREQ'(1) << owner) : '0;
    assign resp_data  = (state == RESP) ? res_q : 32'd0;
    assign resp_err   = (state == RESP) && err_q;
    assign busy       = (state != IDLE);

    assign alu_idata  = instr_q;
    assign alu_rv1    = rv1_q;
    assign alu_rv2    = rv2_q;

endmodule

// File: tb/tb_r_alu_arbiter.sv
// Self-checking bench for r_alu_arbiter: transaction-level model checked every cycle,
// plus directed vectors whose expected values are written out by hand.
module tb_r_alu_arbiter;

    localparam int NREQ = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [32*NREQ-1:0]  req_instr;
    logic [32*NREQ-1:0]  req_rv1;
    logic [32*NREQ-1:0]  req_rv2;
    logic [NREQ-1:0]     resp_valid;
    logic [NREQ-1:0]     resp_ready;
    logic [31:0]         resp_data;
    logic                resp_err;
    logic [31:0]         alu_idata;
    logic [31:0]         alu_rv1;
    logic [31:0]         alu_rv2;
    logic [31:0]         alu_result;
    logic                busy;
    logic [15:0]         op_count;

    logic [31:0] drv_instr [NREQ];
    logic [31:0] drv_a     [NREQ];
    logic [31:0] drv_b     [NREQ];

    int n_tests = 0;
    int n_fail  = 0;

    assign req_instr = {drv_instr[1], drv_instr[0]};
    assign req_rv1   = {drv_a[1], drv_a[0]};
    assign req_rv2   = {drv_b[1], drv_b[0]};

    always #5 clk = ~clk;

    r_alu_arbiter #(.NREQ(NREQ)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_instr  (req_instr),
        .req_rv1    (req_rv1),
        .req_rv2    (req_rv2),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .alu_idata  (alu_idata),
        .alu_rv1    (alu_rv1),
        .alu_rv2    (alu_rv2),
        .alu_result (alu_result),
        .busy       (busy),
        .op_count   (op_count)
    );

    // Environment ALU: looks only at funct bits, so illegal words still yield a non-zero result.
    always_comb begin
        alu_result = 32'hDEADBEEF;
        case ({alu_idata[30], alu_idata[14:12]})
            4'b0000: alu_result = alu_rv1 + alu_rv2;
            4'b1000: alu_result = alu_rv1 - alu_rv2;
            4'b0001: alu_result = alu_rv1 << alu_rv2[4:0];
            4'b0010: alu_result = {31'd0, $signed(alu_rv1) < $signed(alu_rv2)};
            4'b0011: alu_result = {31'd0, alu_rv1 < alu_rv2};
            4'b0100: alu_result = alu_rv1 ^ alu_rv2;
            4'b0101: alu_result = alu_rv1 >> alu_rv2[4:0];
            4'b1101: alu_result = 32'($signed(alu_rv1) >>> alu_rv2[4:0]);
            4'b0110: alu_result = alu_rv1 | alu_rv2;
            4'b0111: alu_result = alu_rv1 & alu_rv2;
            default: ;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic bit_at(input logic [31:0] v, input int idx);
        logic [4:0] i5;
        i5 = idx[4:0];
        return v[i5];
    endfunction

    // Architectural meaning of an instruction: {err, result}.
    function automatic logic [32:0] model_op(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        if (i[6:0] != 7'h33) return {1'b1, 32'd0};
        if (i[31:25] == 7'h00) begin
            case (i[14:12])
                3'd0:    return {1'b0, a + b};
                3'd1:    return {1'b0, a << sh};
                3'd2:    return {1'b0, 31'd0, $signed(a) < $signed(b)};
                3'd3:    return {1'b0, 31'd0, a < b};
                3'd4:    return {1'b0, a ^ b};
                3'd5:    return {1'b0, a >> sh};
                3'd6:    return {1'b0, a | b};
                default: return {1'b0, a & b};
            endcase
        end
        if (i[31:25] == 7'h20 && i[14:12] == 3'd0) return {1'b0, a - b};
        if (i[31:25] == 7'h20 && i[14:12] == 3'd5) return {1'b0, 32'($signed(a) >>> sh)};
        return {1'b1, 32'd0};
    endfunction

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3);
        return {f7, 5'd3, 5'd2, f3, 5'd1, 7'h33};
    endfunction

    // Transaction model: phase 0 idle, 1 executing, 2 responding.
    int          m_phase;
    int          m_last;
    int          m_owner;
    int          exp_win;
    int          cand;
    logic [15:0] m_count;
    logic [31:0] m_instr, m_a, m_b, m_res, exp_rr;
    logic        m_err;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_phase = 0;
            m_last  = NREQ - 1;
            m_count = 16'd0;
            m_instr = 32'd0;
            m_a     = 32'd0;
            m_b     = 32'd0;
            check("rst_req_ready", 32'(req_ready), 32'd0);
            check("rst_resp_valid", 32'(resp_valid), 32'd0);
            check("rst_resp_data", resp_data, 32'd0);
            check("rst_resp_err", 32'(resp_err), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_op_count", 32'(op_count), 32'd0);
            check("rst_alu_idata", alu_idata, 32'd0);
            check("rst_alu_rv1", alu_rv1, 32'd0);
            check("rst_alu_rv2", alu_rv2, 32'd0);
        end else begin
            check("op_count", 32'(op_count), 32'(m_count));
            check("alu_idata", alu_idata, m_instr);
            check("alu_rv1", alu_rv1, m_a);
            check("alu_rv2", alu_rv2, m_b);
            check("busy", 32'(busy), (m_phase != 0) ? 32'd1 : 32'd0);
            case (m_phase)
                0: begin
                    exp_win = -1;
                    for (int k = 1; k <= NREQ; k++) begin
                        cand = (m_last + k) % NREQ;
                        if (exp_win < 0 && bit_at(32'(req_valid), cand)) exp_win = cand;
                    end
                    exp_rr = (exp_win >= 0) ? (32'd1 << exp_win) : 32'd0;
                    check("req_ready", 32'(req_ready), exp_rr);
                    check("idle_resp_valid", 32'(resp_valid), 32'd0);
                    if (exp_win >= 0) begin
                        m_owner = exp_win;
                        m_last  = exp_win;
                        m_instr = 32'(req_instr >> (32 * exp_win));
                        m_a     = 32'(req_rv1 >> (32 * exp_win));
                        m_b     = 32'(req_rv2 >> (32 * exp_win));
                        m_phase = 1;
                    end
                end
                1: begin
                    check("exec_req_ready", 32'(req_ready), 32'd0);
                    check("exec_resp_valid", 32'(resp_valid), 32'd0);
                    {m_err, m_res} = model_op(m_instr, m_a, m_b);
                    m_phase = 2;
                end
                default: begin
                    check("resp_req_ready", 32'(req_ready), 32'd0);
                    check("resp_valid", 32'(resp_valid), 32'd1 << m_owner);
                    check("resp_data", resp_data, m_res);
                    check("resp_err", 32'(resp_err), 32'(m_err));
                    if (bit_at(32'(resp_ready), m_owner)) begin
                        if (!m_err) m_count = m_count + 16'd1;
                        m_phase = 0;
                    end
                end
            endcase
        end
    end

    // Full operation from requester r with resp_ready already high; expected values are literals.
    task automatic do_op(input logic [0:0] r, input logic [31:0] instr, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_data, input logic exp_err,
                         input string name);
        int n;
        drv_instr[r] = instr;
        drv_a[r]     = a;
        drv_b[r]     = b;
        req_valid[r] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready[r] && n < 20) begin
            n++;
            @(negedge clk);
        end
        check({name, "_accept"}, 32'(req_ready[r]), 32'd1);
        @(posedge clk);
        #1;
        req_valid[r] = 1'b0;
        n = 1;
        @(negedge clk);
        while (!resp_valid[r] && n < 20) begin
            n++;
            @(negedge clk);
        end
        check({name, "_latency"}, 32'(n), 32'd2);
        check({name, "_data"}, resp_data, exp_data);
        check({name, "_err"}, 32'(resp_err), 32'(exp_err));
        @(posedge clk);
        #1;
    endtask

    logic [31:0] ops_instr [10];
    logic [31:0] ops_exp   [10];

    initial begin
        int n;
        logic [31:0] exp_g;
        rst_n      = 1'b0;
        req_valid  = '0;
        resp_ready = '1;
        for (int i = 0; i < NREQ; i++) begin
            drv_instr[i] = 32'd0;
            drv_a[i]     = 32'd0;
            drv_b[i]     = 32'd0;
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        do_op(1'b0, 32'h003100B3, 32'd5, 32'd7, 32'd12, 1'b0, "single_add");
        check("single_add_op_count", 32'(op_count), 32'd1);

        ops_instr[0] = mk(7'h00, 3'd0); ops_exp[0] = 32'h80000006;
        ops_instr[1] = mk(7'h20, 3'd0); ops_exp[1] = 32'h80000002;
        ops_instr[2] = mk(7'h00, 3'd1); ops_exp[2] = 32'h00000010;
        ops_instr[3] = mk(7'h00, 3'd2); ops_exp[3] = 32'h00000001;
        ops_instr[4] = mk(7'h00, 3'd3); ops_exp[4] = 32'h00000000;
        ops_instr[5] = mk(7'h00, 3'd4); ops_exp[5] = 32'h80000006;
        ops_instr[6] = mk(7'h00, 3'd5); ops_exp[6] = 32'h20000001;
        ops_instr[7] = mk(7'h20, 3'd5); ops_exp[7] = 32'hE0000001;
        ops_instr[8] = mk(7'h00, 3'd6); ops_exp[8] = 32'h80000006;
        ops_instr[9] = mk(7'h00, 3'd7); ops_exp[9] = 32'h00000000;
        for (int i = 0; i < 10; i++)
            do_op(1'b1, ops_instr[i], 32'h80000004, 32'h00000002, ops_exp[i], 1'b0, $sformatf("op%0d", i));
        check("ops_op_count", 32'(op_count), 32'd11);

        // Both requesters held: grants must alternate starting at 0.
        drv_instr[0] = 32'h003100B3; drv_a[0] = 32'd1;  drv_b[0] = 32'd1;
        drv_instr[1] = 32'h003100B3; drv_a[1] = 32'd10; drv_b[1] = 32'd20;
        req_valid = 2'b11;
        for (int g = 0; g < 4; g++) begin
            exp_g = (g % 2 == 0) ? 32'd1 : 32'd2;
            n = 0;
            @(negedge clk);
            while (req_ready == '0 && n < 20) begin
                n++;
                @(negedge clk);
            end
            check("rr_grant", 32'(req_ready), exp_g);
            @(posedge clk);
            #1;
            if (g == 3) req_valid = '0;
            n = 0;
            @(negedge clk);
            while (resp_valid == '0 && n < 20) begin
                n++;
                @(negedge clk);
            end
            check("rr_resp_owner", 32'(resp_valid), exp_g);
            check("rr_resp_data", resp_data, (g % 2 == 0) ? 32'd2 : 32'd30);
            @(posedge clk);
            #1;
        end
        check("rr_op_count", 32'(op_count), 32'd15);

        do_op(1'b0, 32'h00310093, 32'd5, 32'd7, 32'd0, 1'b1, "illegal_opcode");
        do_op(1'b1, 32'h423100B3, 32'd5, 32'd7, 32'd0, 1'b1, "illegal_f7");
        check("illegal_op_count", 32'(op_count), 32'd15);

        // Backpressure on requester 0 while requester 1 waits.
        resp_ready[0] = 1'b0;
        drv_instr[0] = 32'h003100B3; drv_a[0] = 32'd5; drv_b[0] = 32'd7;
        drv_instr[1] = mk(7'h20, 3'd0); drv_a[1] = 32'd9; drv_b[1] = 32'd4;
        req_valid[0] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready[0] && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("bp_accept0", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 2'b10;
        n = 0;
        @(negedge clk);
        while (!resp_valid[0] && n < 20) begin
            n++;
            @(negedge clk);
        end
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_data", resp_data, 32'd12);
            check("bp_hold_valid", 32'(resp_valid), 32'd1);
            check("bp_hold_ready1", 32'(req_ready[1]), 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        resp_ready[0] = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("bp_accept1_next", 32'(req_ready), 32'd2);
        @(posedge clk);
        #1;
        req_valid = '0;
        n = 0;
        @(negedge clk);
        while (!resp_valid[1] && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("bp_resp1_data", resp_data, 32'd5);
        @(posedge clk);
        #1;
        check("bp_op_count", 32'(op_count), 32'd17);

        // Reset pulse while the operation is in EXEC.
        drv_instr[0] = 32'h003100B3; drv_a[0] = 32'd5; drv_b[0] = 32'd7;
        req_valid[0] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready[0] && n < 20) begin
            n++;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        rst_n = 1'b0;
        #1;
        check("rst_exec_busy", 32'(busy), 32'd0);
        check("rst_exec_op_count", 32'(op_count), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_no_resp", 32'(resp_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        drv_instr[1] = 32'h003100B3; drv_a[1] = 32'd100; drv_b[1] = 32'd1;
        req_valid = 2'b11;
        n = 0;
        @(negedge clk);
        while (req_ready == '0 && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("rst_first_grant", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = '0;
        n = 0;
        @(negedge clk);
        while (resp_valid == '0 && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("rst_resp_owner", 32'(resp_valid), 32'd1);
        check("rst_resp_data12", resp_data, 32'd12);
        @(posedge clk);
        #1;
        check("final_op_count", 32'(op_count), 32'd1);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/r_alu_arbiter.md
# r_alu_arbiter

Round-robin arbiter and sequencer that shares one combinational R-type ALU among `NREQ` requesters, such as the integer pipe and a debug/test port. Each request carries a 32-bit R-type instruction word and two operands. The block validates the opcode/funct fields, presents the registered operands to the shared ALU, and captures the ALU result. It then returns the result to the winning requester over a valid/ready handshake. The block sits between the requesters and the R-type ALU datapath; the ALU itself stays purely combinational.

## Interface
- `NREQ`, default 2: number of requesters, legal range 2..4.
- `clk`  in  1  system clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_ready`  out  NREQ  per-requester accept; one-hot or zero.
- `req_instr`  in  32*NREQ  packed instruction words; requester i is at bits [32i+31:32i].
- `req_rv1`, `req_rv2`  in  32*NREQ  packed source operands, same packing.
- `resp_valid`  out  NREQ  per-requester result valid; one-hot or zero.
- `resp_ready`  in  NREQ  per-requester result accept.
- `resp_data`  out  32  result, shared by all requesters; qualify with `resp_valid`.
- `resp_err`  out  1  illegal instruction flag, qualified with `resp_valid`.
- `alu_idata`  out  32  instruction word driven to the ALU.
- `alu_rv1`, `alu_rv2`  out  32  operands driven to the ALU.
- `alu_result`  in  32  combinational ALU result.
- `busy`  out  1  high in any state except IDLE.
- `op_count`  out  16  count of completed legal operations.

## Operation
- FSM states:
  - IDLE:
    - Select a winner among the asserted `req_valid` bits, searching round-robin starting at `last_grant+1` mod NREQ.
    - Drive `req_ready[winner]`=1 combinationally in this same cycle.
    - On the clock edge, latch the winner's instr, rv1 and rv2, record `owner`, update `last_grant`=winner, and move to EXEC.
    - With no request, stay in IDLE with `req_ready`=0.
  - EXEC:
    - The `alu_*` outputs are driven from the latched registers.
    - Capture `alu_result` into `res_q` and the decode error into `err_q`, then move to RESP.
  - RESP:
    - `resp_valid[owner]`=1, with `resp_data`=`res_q` and `resp_err`=`err_q`.
    - When `resp_ready[owner]`=1, move to IDLE; if `err_q`=0, also increment `op_count`.
    - `resp_ready` bits of other requesters are ignored.
- Decode is legal only if all of the following hold:
  - `instr[6:0]`=7'b0110011, `instr[31]`=0 and `instr[29:25]`=0.
  - {`instr[30]`, `instr[14:12]`} is one of: 0000 add, 1000 sub, 0001 sll, 0010 slt, 0011 sltu, 0100 xor, 0101 srl, 1101 sra, 0110 or, 0111 and.
- On an illegal decode: `err_q`=1, `res_q`=0, and the ALU output is discarded. The response is still delivered but `op_count` is not incremented.
- `alu_*` outputs hold the latched values in all states; in IDLE they hold the last operation's values.
- `op_count` wraps from 16'hFFFF to 0.
- Requester input rules:
  - A requester may deassert `req_valid` before it is accepted; the request is then simply not seen.
  - Inputs are sampled only in the IDLE accept cycle.
  - A requester may keep `req_valid` high after acceptance; that is a new request.

## Timing
- Reset values (asynchronous, immediate on `rst_n`=0):
  - state=IDLE, `last_grant`=NREQ-1 (so requester 0 wins first).
  - `req_ready`=0, `resp_valid`=0, `resp_data`=0, `resp_err`=0, `busy`=0, `op_count`=0.
  - Latched instr, rv1 and rv2 = 0, so the `alu_*` outputs = 0.
- Latency:
  - Accept edge at cycle 0, EXEC in cycle 1, `resp_valid` high from cycle 2.
  - Minimum of 3 cycles per operation when `resp_ready` is already high; the arbiter is not pipelined.
- `req_ready` is high only in IDLE, and for at most one requester per cycle.
- `resp_valid`, `resp_data` and `resp_err` are stable from entering RESP until the handshake completes.
- Backpressure: RESP holds indefinitely while `resp_ready[owner]`=0; no other request is accepted meanwhile.
- Simultaneous requests: exactly one is granted per IDLE cycle. A requester that loses is granted within NREQ operations while it holds `req_valid`.
- Reset mid-operation aborts the operation, returning the block to IDLE with reset values. No response is issued and `op_count` is unchanged (0).

## Test plan
- Single add: requester 0 sends instr 0x003100B3 (add), rv1=5, rv2=7 -> `req_ready[0]` in cycle 0, `resp_valid[0]` in cycle 2 with `resp_data`=12 and `resp_err`=0; `op_count`=1.
- All ten ops from requester 1 with rv1=0x80000004 and rv2=0x00000002 -> results:
  - add 0x80000006, sub 0x80000002, sll 0x00000010
  - slt 1, sltu 0, xor 0x80000006
  - srl 0x20000001, sra 0xE0000001
  - or 0x80000006, and 0
- Contention: NREQ=2 with both `req_valid` held for 4 operations -> grant order 0,1,0,1; each response appears only on its owner's `resp_valid`.
- Illegal instructions: opcode 0x13, and funct7 0x21 with a legal funct3 -> `resp_err`=1 and `resp_data`=0; `op_count` is unchanged.
- Backpressure: hold `resp_ready[0]`=0 for 5 cycles while requester 1 requests -> `resp_data` is stable and `req_ready[1]` stays 0; after `resp_ready[0]` is raised, requester 1 is accepted the following cycle.
- Reset in EXEC: pulse `rst_n` low for one cycle -> all outputs return to reset values and no `resp_valid` follows; the next request is granted to requester 0.
